// File: rtl/board_window_reader.sv
// Reads the 4x4 board window under a falling piece, one row per cycle, and reports
// the raw window plus collision and out-of-bounds flags for the latched piece mask.
module board_window_reader (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [9:0]   Block_X_Pos,
    input  logic [9:0]   Block_Y_Pos,
    input  logic [15:0]  piece_mask,
    input  logic [239:0] board_state,
    output logic         busy,
    output logic         done,
    output logic [15:0]  window,
    output logic         collision,
    output logic         out_of_bounds
);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t      state;
    logic [5:0]  col_q;
    logic [5:0]  row_q;
    logic [15:0] mask_q;
    logic [1:0]  row_cnt;
    logic [15:0] win_acc;
    logic        oob_acc;

    logic [6:0]  cell_row;
    logic [6:0]  cell_col;
    logic [3:0]  row_bits;
    logic [3:0]  row_oob;
    logic [3:0]  row_mask;
    logic        oob_now;
    logic [15:0] win_full;

    // Cell coordinates are 7 bits wide so col/row up to 51+3 never alias onto a real cell.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        row_bits = '0;
        row_oob  = '0;
        cell_col = '0;
        cell_row = 7'(row_q) + 7'(row_cnt);
        for (int c = 0; c < 4; c++) begin
            cell_col = 7'(col_q) + 7'(c);
            if (cell_col <= 7'd9 && cell_row <= 7'd23) begin
                row_bits[c] = board_state[8'(cell_row) * 8'd10 + 8'(cell_col)];
            end else begin
                row_bits[c] = 1'b1;
                row_oob[c]  = 1'b1;
            end
        end
        row_mask = mask_q[{row_cnt, 2'b00} +: 4];
        oob_now  = |(row_oob & row_mask);
        win_full = {row_bits, win_acc[11:0]};
    end

    // NOTE: all state below is written with non-blocking assignments so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            row_cnt       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            window        <= '0;
            collision     <= 1'b0;
            out_of_bounds <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
            mask_q        <= '0;
            win_acc       <= '0;
            oob_acc       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        col_q   <= 6'(Block_X_Pos / 10'd20);
                        row_q   <= 6'(Block_Y_Pos / 10'd20);
                        mask_q  <= piece_mask;
                        row_cnt <= '0;
                        win_acc <= '0;
                        oob_acc <= 1'b0;
                        busy    <= 1'b1;
                        state   <= READ;
                    end
                end
                READ: begin
                    win_acc[{row_cnt, 2'b00} +: 4] <= row_bits;
                    oob_acc <= oob_acc | oob_now;
                    row_cnt <= row_cnt + 2'd1;
                    if (row_cnt == 2'd3) begin
                        // Last row folds in combinationally so results land exactly at DONE entry.
                        window        <= win_full;
                        collision     <= |(win_full & mask_q);
                        out_of_bounds <= oob_acc | oob_now;
                        done          <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_window_reader.sv
// Directed bench for board_window_reader: expected results are queued at start and
// compared when done pulses; latency, busy span and reset abort are checked too.
module tb_board_window_reader;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [9:0]   Block_X_Pos;
    logic [9:0]   Block_Y_Pos;
    logic [15:0]  piece_mask;
    logic [239:0] board_state;
    logic         busy;
    logic         done;
    logic [15:0]  window;
    logic         collision;
    logic         out_of_bounds;

    typedef struct {
        logic [15:0] win;
        logic        coll;
        logic        oob;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    board_window_reader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .Block_X_Pos   (Block_X_Pos),
        .Block_Y_Pos   (Block_Y_Pos),
        .piece_mask    (piece_mask),
        .board_state   (board_state),
        .busy          (busy),
        .done          (done),
        .window        (window),
        .collision     (collision),
        .out_of_bounds (out_of_bounds)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic exp_t model(input int x, input int y, input logic [15:0] m,
                                   input logic [239:0] b);
        exp_t e;
        int   col, row, cc, rr;
        col = x / 20;
        row = y / 20;
        e.win = '0;
        e.oob = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                cc = col + c;
                rr = row + r;
                if (cc <= 9 && rr <= 23) begin
                    e.win[4*r+c] = b[rr*10+cc];
                end else begin
                    e.win[4*r+c] = 1'b1;
                    if (m[4*r+c]) e.oob = 1'b1;
                end
            end
        end
        e.coll = |(e.win & m);
        return e;
    endfunction

    task automatic push_exp(input logic [15:0] w, input logic c, input logic o);
        exp_t e;
        e.win  = w;
        e.coll = c;
        e.oob  = o;
        exp_q.push_back(e);
    endtask

    // Steps until done or the budget runs out; returns cycles waited.
    task automatic wait_done(input string tag, output int waited);
        waited = 0;
        while (done !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        if (done !== 1'b1) check({tag, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_window"}, 32'(window), 32'(e.win));
            check({tag, "_collision"}, 32'(collision), 32'(e.coll));
            check({tag, "_oob"}, 32'(out_of_bounds), 32'(e.oob));
        end
    endtask

    // One full transaction: latency from the start-sampling edge and busy span are checked.
    task automatic run_op(input string tag, input int x, input int y, input logic [15:0] m);
        int lat, busy_cnt, waited;
        Block_X_Pos = 10'(x);
        Block_Y_Pos = 10'(y);
        piece_mask  = m;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        busy_cnt = busy ? 1 : 0;
        while (done !== 1'b1 && lat < 20) begin
            step();
            lat++;
            if (busy) busy_cnt++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd5);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd5);
        compare_result(tag);
        step();
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_after"}, 32'(done), 32'd0);
        waited = 0;
    endtask

    initial begin
        int waited, done_cnt, last_done;
        int bx[4], by[4];
        logic [15:0] bm[4];
        exp_t e;

        reset = 1'b1;
        start = 1'b0;
        Block_X_Pos = '0;
        Block_Y_Pos = '0;
        piece_mask  = '0;
        board_state = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_window", 32'(window), 32'd0);
        check("rst_flags", {30'd0, collision, out_of_bounds}, 32'd0);

        // Empty board, piece fully inside.
        push_exp(16'h0000, 1'b0, 1'b0);
        run_op("empty_mid", 60, 100, 16'h0660);

        // Single occupied cell at row 6 col 4 -> window bit 5.
        board_state = '0;
        board_state[64] = 1'b1;
        push_exp(16'h0020, 1'b1, 1'b0);
        run_op("bit64", 60, 100, 16'h0660);

        // Right wall at col 8.
        board_state = '0;
        push_exp(16'hCCCC, 1'b1, 1'b1);
        run_op("wall_hit", 160, 0, 16'h000F);
        push_exp(16'hCCCC, 1'b0, 1'b0);
        run_op("wall_clear", 160, 0, 16'h0003);

        // Floor at row 22.
        push_exp(16'hFF00, 1'b1, 1'b1);
        run_op("floor", 0, 440, 16'hF000);

        // Far off-board position must not wrap onto real cells.
        push_exp(16'hFFFF, 1'b1, 1'b1);
        run_op("far_off", 1023, 1023, 16'h0001);

        // Reset on the second READ cycle aborts silently and clears results.
        board_state = '1;
        Block_X_Pos = 10'd60;
        Block_Y_Pos = 10'd100;
        piece_mask  = 16'h0660;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_window", 32'(window), 32'd0);
        check("abort_flags", {30'd0, collision, out_of_bounds}, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);

        // Start pulses and input changes during READ are ignored.
        board_state = '0;
        board_state[64] = 1'b1;
        Block_X_Pos = 10'd60;
        Block_Y_Pos = 10'd100;
        piece_mask  = 16'h0660;
        push_exp(16'h0020, 1'b1, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        Block_X_Pos = 10'd0;
        piece_mask  = 16'hFFFF;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("pulses", waited);
        compare_result("pulses");
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) done_cnt++;
        end
        check("pulses_single_done", 32'(done_cnt), 32'd0);

        // Back-to-back with start held high on a random board.
        for (int i = 0; i < 8; i++) board_state[i*30 +: 30] = 30'($urandom);
        bx = '{60, 160, 0, 100};
        by = '{100, 0, 440, 240};
        bm = '{16'h0660, 16'h00F0, 16'h8421, 16'h0F00};
        Block_X_Pos = 10'(bx[0]);
        Block_Y_Pos = 10'(by[0]);
        piece_mask  = bm[0];
        e = model(bx[0], by[0], bm[0], board_state);
        exp_q.push_back(e);
        start = 1'b1;
        step();
        last_done = 0;
        for (int k = 0; k < 4; k++) begin
            wait_done("b2b", waited);
            if (k > 0) check("b2b_period", 32'(cyc - last_done), 32'd6);
            last_done = cyc;
            compare_result("b2b");
            if (k < 3) begin
                Block_X_Pos = 10'(bx[k+1]);
                Block_Y_Pos = 10'(by[k+1]);
                piece_mask  = bm[k+1];
                e = model(bx[k+1], by[k+1], bm[k+1], board_state);
                exp_q.push_back(e);
            end else begin
                start = 1'b0;
            end
            step();
        end
        step();
        step();
        check("final_busy", 32'(busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
